dog_sprite_animator: RTL

- Requester side of the dog sprite ROM interface.
- Sequences the animation frame number: walk frames 0–3 and sniff frames 4–5.
- Computes the 14-bit ROM address from the VGA draw coordinates and the dog position.
- Absorbs the ROM's 1-cycle read latency and delivers a palette index plus an opaque flag aligned to the draw pipeline, for the colour mapper.

---
 rtl/dog_sprite_animator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dog_sprite_animator.sv
// Dog sprite ROM requester: animation frame sequencer (walk/sniff), sprite address
// generation from draw coordinates, and a fixed 2-cycle pixel pipeline for the colour mapper.
module dog_sprite_animator #(
    parameter int SPR_W       = 110,
    parameter int SPR_H       = 86,
    parameter int WALK_TICKS  = 8,
    parameter int SNIFF_TICKS = 16,
    parameter int SNIFF_REPS  = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        sniff_req,
    input  logic [9:0]  dog_x,
    input  logic [9:0]  dog_y,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic [4:0]  rom_frame,
    output logic [13:0] rom_addr,
    input  logic [3:0]  rom_q,
    output logic [3:0]  pixel_idx,
    output logic        pixel_on,
    output logic [1:0]  anim_state
);

    localparam logic [1:0] ST_WALK  = 2'd0;
    localparam logic [1:0] ST_SNIFF = 2'd1;

    localparam logic [7:0] WALK_LAST  = 8'(WALK_TICKS - 1);
    localparam logic [7:0] SNIFF_LAST = 8'(SNIFF_TICKS - 1);
    localparam logic [7:0] REP_LAST   = 8'(SNIFF_REPS - 1);

    logic [1:0]  state_q, state_d;
    logic [4:0]  frame_q, frame_d;
    logic [7:0]  tick_q, tick_d;
    logic [7:0]  rep_q, rep_d;
    logic        pend_q, pend_d;

    logic [10:0] dx, dy;
    logic        in_box_c;
    logic [13:0] addr_c;
    logic [13:0] addr_q;
    logic        in_box_q;
    logic        box_dly_q;

    // Frame sequencer; all frame changes are gated by frame_tick so they land in blanking.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        tick_d  = tick_q;
        rep_d   = rep_q;
        pend_d  = pend_q;
        case (state_q)
            ST_WALK: begin
                pend_d = pend_q | sniff_req;
                if (frame_tick) begin
                    if (tick_q == WALK_LAST) begin
                        tick_d = 8'd0;
                        if (frame_q == 5'd3) begin
                            // A request arriving on the wrap tick itself still qualifies.
                            if (pend_q | sniff_req) begin
                                state_d = ST_SNIFF;
                                frame_d = 5'd4;
                                pend_d  = 1'b0;
                                rep_d   = 8'd0;
                            end else begin
                                frame_d = 5'd0;
                            end
                        end else begin
                            frame_d = frame_q + 5'd1;
                        end
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
            end
            ST_SNIFF: begin
                pend_d = 1'b0;
                if (frame_tick) begin
                    if (tick_q == SNIFF_LAST) begin
                        tick_d = 8'd0;
                        if (frame_q == 5'd4) begin
                            frame_d = 5'd5;
                        end else if (rep_q == REP_LAST) begin
                            state_d = ST_WALK;
                            frame_d = 5'd0;
                            rep_d   = 8'd0;
                        end else begin
                            frame_d = 5'd4;
                            rep_d   = rep_q + 8'd1;
                        end
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_WALK;
                frame_d = 5'd0;
                tick_d  = 8'd0;
                rep_d   = 8'd0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // 11-bit differences plus explicit >= checks keep left/above pixels from wrapping into the box.
    always_comb begin
        dx       = {1'b0, draw_x} - {1'b0, dog_x};
        dy       = {1'b0, draw_y} - {1'b0, dog_y};
        in_box_c = (draw_x >= dog_x) && (dx < 11'(SPR_W)) &&
                   (draw_y >= dog_y) && (dy < 11'(SPR_H));
        addr_c   = in_box_c ? (14'(dy) * 14'(SPR_W) + 14'(dx)) : 14'd0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_WALK;
            frame_q   <= 5'd0;
            tick_q    <= 8'd0;
            rep_q     <= 8'd0;
            pend_q    <= 1'b0;
            addr_q    <= 14'd0;
            in_box_q  <= 1'b0;
            box_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            tick_q    <= tick_d;
            rep_q     <= rep_d;
            pend_q    <= pend_d;
            addr_q    <= addr_c;
            in_box_q  <= in_box_c;
            box_dly_q <= in_box_q;
        end
    end

    // rom_q arrives one cycle after addr_q, aligned with box_dly_q.
    assign pixel_idx  = box_dly_q ? rom_q : 4'd0;
    assign pixel_on   = box_dly_q && (rom_q != 4'd0);
    assign rom_frame  = frame_q;
    assign rom_addr   = addr_q;
    assign anim_state = state_q;

endmodule
